clk_div_bank: RTL
=================

Name: clk_div_bank

Overview:
Multi-channel programmable clock divider bank. It is the parametrised successor to the single-channel divider used for test-pattern pacing. Each channel produces either a 50%-duty divided clock (toggle mode) or a one-cycle strobe (pulse mode), driven by a per-channel divisor. Divisors and modes update at runtime through a valid/ready config port. Updates are shadowed and applied only at a period boundary, so a running output never sees a glitch or truncated phase. A global sync input re-aligns all channels.

Parameters:
N_CH, 4, number of independent divider channels (1..16)
WIDTH, 8, divisor/counter width in bits
CH_W, 2, width of cfg_ch; must be >= max(1, clog2(N_CH))
DEF_DIV, 1, divisor loaded into every channel at reset (must fit WIDTH)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
ch_en  in  N_CH  per-channel run enable
cfg_valid  in  1  config request valid
cfg_ready  out  1  config request accepted this cycle when high with cfg_valid
cfg_ch  in  CH_W  target channel index
cfg_div  in  WIDTH  new divisor D
cfg_mode  in  1  0 = toggle mode, 1 = pulse mode
sync_restart  in  1  one-cycle pulse: restart all channels phase-aligned
clk_gen  out  N_CH  divided outputs (registered)
tick  out  N_CH  one-cycle strobe at each channel terminal count (registered)
pending  out  N_CH  shadow update waiting to be applied, per channel

Behaviour:
- Per-channel state:
  - cnt[WIDTH]
  - active div_q[WIDTH] and mode_q
  - shadow div_sh and mode_sh
  - pend flag
- Reset (rst=1 at a clk edge):
  - cnt=0, div_q=div_sh=DEF_DIV, mode_q=mode_sh=0, pend=0, clk_gen=0, tick=0.
  - rst overrides every other input, including mid-period and mid-config.
- Terminal condition: cnt >= div_q. Use ">=", not "==", for robustness.
- Running channel (ch_en=1), each cycle:
  - Not terminal: cnt<=cnt+1, clk_gen holds, tick<=0.
  - Terminal: cnt<=0 and tick<=1.
    - Toggle mode: clk_gen<=~clk_gen.
    - Pulse mode: clk_gen<=1 for that cycle, else 0. In pulse mode clk_gen equals tick.
  - Periods:
    - Toggle mode: half-period D+1 cycles, full period 2(D+1).
    - Pulse mode: period D+1 cycles. D=0 gives tick every cycle (clk_gen constant 1 in pulse mode, toggling every cycle in toggle mode).
- Applying an update:
  - On a terminal cycle with pend=1: div_q<=div_sh, mode_q<=mode_sh, pend<=0.
  - The new values govern the period that starts on the next cycle. The terminal cycle itself still acts per the old mode.
  - When entering pulse mode, the terminal cycle's clk_gen follows the old mode. The next cycle forces clk_gen per the pulse rule.
- Disabled channel (ch_en=0):
  - cnt<=0, clk_gen<=0, tick<=0.
  - Any pending shadow is applied immediately next cycle.
  - On re-enable, counting starts from cnt=0 with clk_gen=0.
- Config handshake:
  - cfg_ready = !pend[cfg_ch] (combinational) when cfg_ch<N_CH. It is 1 for out-of-range indices.
  - Accept = cfg_valid && cfg_ready. An in-range accept writes div_sh, mode_sh, pend<=1 on that edge.
  - An out-of-range accept is consumed and dropped with no state change.
  - A second write to the same channel stalls (ready low) until the first is applied.
  - Accept and apply cannot coincide on one channel, because ready requires pend=0.
  - cfg_valid may drop without acceptance; there is no obligation to hold.
- sync_restart:
  - For all enabled channels: cnt<=0, clk_gen<=0, tick<=0; pending shadows applied immediately.
  - A config accept in the same cycle still latches into the shadow (pend=1). It is applied at the next terminal.
- Priority: rst > ch_en=0 > sync_restart > terminal > count.
- pending mirrors pend; its reset value is 0.

Test Plan:
- Reset with DEF_DIV=1, ch_en=1 on ch0 -> clk_gen[0] rises on 2nd clk edge after rst deasserts; period 4 cycles, 50% duty; tick[0] high every 2nd cycle.
- Write ch1 D=3 mode=1 mid-period of old D=1 toggle -> pending[1]=1, cfg_ready low for ch1; old half-period completes; then clk_gen[1]=tick[1] single-cycle pulses every 4 cycles; pending[1] clears on the apply edge.
- Back-to-back cfg_valid to ch2 (D=5 then D=2) -> first accepted, second held with cfg_ready=0 until ch2 terminal; then period sequence 2*(5+1)=12 followed by 2*(2+1)=6.
- Channels at D=2,4,6 drifted, pulse sync_restart -> all clk_gen=0 next cycle; first toggles at 3/5/7 cycles after; edges coincide every LCM.
- ch_en[0]=0 for 10 cycles with pending write D=0 -> clk_gen[0]=0 throughout, pending clears next cycle; after re-enable clk_gen toggles every cycle.
- cfg_ch=7 with N_CH=4, and rst asserted mid-period -> write dropped with cfg_ready=1 and no state change; after rst all outputs 0, divisors back to DEF_DIV.

Source files
------------

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock divider bank: per-channel toggle/pulse outputs with
// shadowed divisor/mode updates applied only at period boundaries.
module clk_div_bank #(
   parameter int N_CH    = 4,
   parameter int WIDTH   = 8,
   parameter int CH_W    = 2,
   parameter int DEF_DIV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  ch_en,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [WIDTH-1:0] cfg_div,
   input  logic             cfg_mode,
   input  logic             sync_restart,
   output logic [N_CH-1:0]  clk_gen,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  pending
);

   localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);

   logic [N_CH-1:0] ch_sel;
   logic [N_CH-1:0] pend_vec;
   logic            cfg_accept;

   // Out-of-range indices select no channel, so they read as ready and are dropped.
   assign cfg_ready  = ~|(ch_sel & pend_vec);
   assign cfg_accept = cfg_valid & cfg_ready;
   assign pending    = pend_vec;

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [WIDTH-1:0] cnt_q, cnt_d;
         logic [WIDTH-1:0] div_q, div_d;
         logic [WIDTH-1:0] div_sh_q, div_sh_d;
         logic             mode_q, mode_d;
         logic             mode_sh_q, mode_sh_d;
         logic             pend_q, pend_d;
         logic             clk_gen_q, clk_gen_d;
         logic             tick_q, tick_d;
         logic             terminal;
         logic             apply;
         logic             wr;

         assign ch_sel[gi]   = (cfg_ch == CH_W'(gi));
         assign pend_vec[gi] = pend_q;
         assign clk_gen[gi]  = clk_gen_q;
         assign tick[gi]     = tick_q;
         assign wr           = cfg_accept & ch_sel[gi];
         assign terminal     = (cnt_q >= div_q);

         always_comb begin
            cnt_d     = cnt_q;
            div_d     = div_q;
            mode_d    = mode_q;
            div_sh_d  = div_sh_q;
            mode_sh_d = mode_sh_q;
            pend_d    = pend_q;
            clk_gen_d = clk_gen_q;
            tick_d    = 1'b0;
            apply     = 1'b0;

            if (!ch_en[gi] || sync_restart) begin
               cnt_d     = '0;
               clk_gen_d = 1'b0;
               apply     = pend_q;
            end else if (terminal) begin
               // The terminal cycle still follows the old mode; a new mode takes over next cycle.
               cnt_d     = '0;
               tick_d    = 1'b1;
               clk_gen_d = mode_q ? 1'b1 : ~clk_gen_q;
               apply     = pend_q;
            end else begin
               cnt_d = cnt_q + WIDTH'(1);
               if (mode_q) begin
                  clk_gen_d = 1'b0;
               end
            end

            // A write needs pend=0, so it can never collide with an apply.
            if (apply) begin
               div_d  = div_sh_q;
               mode_d = mode_sh_q;
               pend_d = 1'b0;
            end else if (wr) begin
               div_sh_d  = cfg_div;
               mode_sh_d = cfg_mode;
               pend_d    = 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_q     <= '0;
               div_q     <= DEF_DIV_W;
               div_sh_q  <= DEF_DIV_W;
               mode_q    <= 1'b0;
               mode_sh_q <= 1'b0;
               pend_q    <= 1'b0;
               clk_gen_q <= 1'b0;
               tick_q    <= 1'b0;
            end else begin
               cnt_q     <= cnt_d;
               div_q     <= div_d;
               div_sh_q  <= div_sh_d;
               mode_q    <= mode_d;
               mode_sh_q <= mode_sh_d;
               pend_q    <= pend_d;
               clk_gen_q <= clk_gen_d;
               tick_q    <= tick_d;
            end
         end
      end
   endgenerate

endmodule
